// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: fetch PC, single outstanding imem read, small
// {pc, word} buffer toward decode, and redirect handling with in-flight discard.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                       r_state, w_state_nxt;
  logic [31:0]                  r_fetch_pc, w_fetch_pc_nxt;
  logic                         w_req_nxt;
  logic [31:0]                  w_addr_nxt;
  logic [FIFO_DEPTH-1:0][63:0]  r_mem;
  logic [AW-1:0]                r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic [CW-1:0]                r_cnt, w_cnt_nxt;
  logic                         w_ack, w_pop, w_push, w_room;
  logic [31:0]                  w_target;
  logic [63:0]                  w_head_nxt;

  assign w_target = redirect_pc & ~32'h3;
  // an ack only counts against a request we are actually driving
  assign w_ack    = imem_req & imem_ack;
  assign w_pop    = inst_valid & inst_ready;
  assign w_push   = w_ack & (r_state == FETCH) & ~redirect_valid;

  always_comb begin
    w_wr_nxt  = r_wr;
    w_rd_nxt  = r_rd;
    w_cnt_nxt = r_cnt;
    if (redirect_valid) begin
      w_wr_nxt  = '0;
      w_rd_nxt  = '0;
      w_cnt_nxt = '0;
    end else begin
      w_wr_nxt  = r_wr + AW'(w_push);
      w_rd_nxt  = r_rd + AW'(w_pop);
      w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // room for one more outstanding read once this cycle's push/pop settle
  assign w_room = (w_cnt_nxt < DEPTH_C);

  // the entry being written this cycle becomes head when nothing older remains
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_push && (r_wr == w_rd_nxt)) w_head_nxt = {imem_addr, imem_rdata};
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_nxt      = imem_req;
    w_addr_nxt     = imem_addr;
    if (redirect_valid) begin
      w_fetch_pc_nxt = w_target;
      if ((r_state != IDLE) && !w_ack) begin
        w_state_nxt = DRAIN;
      end else begin
        w_state_nxt = FETCH;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = w_target;
      end
    end else begin
      case (r_state)
        IDLE: if (w_room) begin
          w_state_nxt = FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
        end
        FETCH: if (w_ack) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (w_room) begin
            w_addr_nxt = r_fetch_pc + 32'd4;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
          end
        end
        // fetch_pc already holds the redirect target; the returned word is dropped
        DRAIN: if (w_ack) begin
          if (w_room) begin
            w_state_nxt = FETCH;
            w_addr_nxt  = r_fetch_pc;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_req_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_mem      <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      imem_req   <= w_req_nxt;
      imem_addr  <= w_addr_nxt;
      r_wr       <= w_wr_nxt;
      r_rd       <= w_rd_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_push) r_mem[r_wr] <= {imem_addr, imem_rdata};
      inst_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        inst_pc <= w_head_nxt[63:32];
        inst    <= w_head_nxt[31:0];
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t        q[$];
  logic [31:0] m_fpc, m_addr;
  logic        m_busy, m_stale;
  int          checks = 0;
  int          fails  = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0001_0820;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_fpc   = RESET_PC;
    m_addr  = RESET_PC;
  endtask

  // one clock edge of the fetch front end, stated as queue operations
  task automatic model_step();
    logic pop, ackd;
    pop  = (q.size() > 0) && inst_ready;
    ackd = m_busy && imem_ack;
    if (pop) void'(q.pop_front());
    if (redirect_valid) begin
      q.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
      if (m_busy && !ackd) m_stale = 1'b1;
      else begin
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_addr  = m_fpc;
      end
    end else begin
      if (ackd) begin
        if (!m_stale) begin
          q.push_back('{m_addr, imem_rdata});
          m_fpc = m_fpc + 32'd4;
        end
        m_stale = 1'b0;
        m_busy  = 1'b0;
      end
      if (!m_busy && (q.size() < DEPTH)) begin
        m_busy = 1'b1;
        m_addr = m_fpc;
      end
    end
    if (q.size() > DEPTH) chk("model_overflow", q.size(), DEPTH);
  endtask

  task automatic compare();
    chk("req", imem_req, m_busy);
    if (m_busy) chk("addr", imem_addr, m_addr);
    chk("valid", inst_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("inst", inst, q[0].w);
      chk("inst_pc", inst_pc, q[0].pc);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare();
    imem_rdata = imem_req ? memw(imem_addr) : $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic zw;
    model_reset();
    #2;
    // 1: zero-wait streaming
    imem_ack = 1'b1; inst_ready = 1'b1;
    do_reset();
    cyc();
    chk("t1_req", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", inst_valid, 1'b0);
    cyc();
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_pc0", inst_pc, 32'h0);
    chk("t1_inst0", inst, 32'h0001_0820);
    cyc();
    chk("t1_addr2", imem_addr, 32'h8);
    chk("t1_pc1", inst_pc, 32'h4);
    // 3: redirect during a 3-cycle wait on addr 0x8
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_hold_addr", imem_addr, 32'h8);
    chk("t3_hold_req", imem_req, 1'b1);
    chk("t3_flushed", inst_valid, 1'b0);
    cyc();
    chk("t3_hold_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1;
    cyc();
    chk("t3_new_addr", imem_addr, 32'h40);
    chk("t3_no_stale", inst_valid, 1'b0);
    cyc();
    chk("t3_pc", inst_pc, 32'h40);
    chk("t3_valid", inst_valid, 1'b1);
    // 2: back-pressure fills the buffer
    imem_ack = 1'b1; inst_ready = 1'b0;
    do_reset();
    cyc();
    cyc();
    cyc();
    chk("t2_req_drop", imem_req, 1'b0);
    chk("t2_frozen_pc", inst_pc, 32'h0);
    cyc();
    chk("t2_req_still0", imem_req, 1'b0);
    chk("t2_frozen_pc2", inst_pc, 32'h0);
    chk("t2_frozen_inst", inst, 32'h0001_0820);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("t2_next_pc", inst_pc, 32'h4);
    chk("t2_req_again", imem_req, 1'b1);
    chk("t2_addr8", imem_addr, 32'h8);
    // 4: redirect coinciding with ack, unaligned target
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h13;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_empty", inst_valid, 1'b0);
    chk("t4_addr", imem_addr, 32'h10);
    // 5: address wrap at top of memory
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
    cyc();
    chk("t5_pc_wrap", inst_pc, 32'h0);
    // 6: reset mid-wait, ack held through and after reset
    imem_ack = 1'b0;
    cyc();
    imem_ack = 1'b1;
    do_reset();
    cyc();
    chk("t6_first_addr", imem_addr, RESET_PC);
    chk("t6_late_ack", inst_valid, 1'b0);
    cyc();
    chk("t6_pc", inst_pc, RESET_PC);
    // randomized traffic
    zw = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) zw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) do_reset();
      imem_ack       = imem_req ? (zw || ($urandom_range(0, 2) == 0)) : ($urandom_range(0, 3) == 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
